// File: rtl/bk_status_scan_pkg.sv
// Shared types and constants for the bk_status_scan sweep controller.
// Holds the FSM state encoding and the bkt write-cycle shape.
package bk_status_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HWR,
    S_SEL,
    S_SETTLE,
    S_SAMPLE,
    S_RST
  } state_t;

  localparam int WR_HOLD   = 2;
  localparam int WR_TAIL   = 2;
  localparam int SW_OFFSET = 1;

endpackage

// File: rtl/bk_bkt_wr_engine.sv
// bkt bus write engine: one request becomes WR_HOLD strobe cycles
// followed by WR_TAIL cycles with index/data still held.
module bk_bkt_wr_engine
  import bk_status_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] idx,
  input  logic [31:0] dat,
  output logic        bkt_ready_o,
  output logic [31:0] bkt_index_o,
  output logic [31:0] bkt_data_o,
  output logic        done
);

  localparam int LEN = WR_HOLD + WR_TAIL;
  localparam logic [2:0] HOLD_LAST = 3'(WR_HOLD - 1);
  localparam logic [2:0] LEN_LAST  = 3'(LEN - 1);

  logic       active;
  logic [2:0] cnt;

  assign done = active && (cnt == LEN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      cnt         <= '0;
      bkt_ready_o <= 1'b0;
      bkt_index_o <= '0;
      bkt_data_o  <= '0;
    end else if (start) begin
      active      <= 1'b1;
      cnt         <= '0;
      bkt_ready_o <= 1'b1;
      bkt_index_o <= idx;
      bkt_data_o  <= dat;
    end else if (active) begin
      cnt <= cnt + 3'd1;
      if (cnt == HOLD_LAST)
        bkt_ready_o <= 1'b0;
      if (done)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/bk_status_scan.sv
// Sweep controller and bkt-bus arbiter for bk_status_sw.
// Define BK_STATUS_SCAN_CHG_EN to build in per-source change detection.
module bk_status_scan
  import bk_status_scan_pkg::*;
#(
  parameter int BKP_BASE_index = 500,
  parameter int NUM_SRC        = 3,
  parameter int SETTLE_CYC     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en_i,
  input  logic        host_ready_i,
  input  logic [31:0] host_index_i,
  input  logic [31:0] host_data_i,
  output logic        bkt_ready_o,
  output logic [31:0] bkt_index_o,
  output logic [31:0] bkt_data_o,
  input  logic [31:0] bk_status_i,
  output logic [31:0] snap0_o,
  output logic [31:0] snap1_o,
  output logic [31:0] snap2_o,
  output logic [2:0]  chg_o,
  input  logic [2:0]  chg_clr_i,
  output logic        scan_done_o,
  output logic        busy_o,
  output logic        host_ovf_o
);

  localparam logic [31:0] SEL_IDX = 32'(BKP_BASE_index + SW_OFFSET);
  localparam logic [1:0]  LAST_SEL = 2'(NUM_SRC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t      state, state_nx;
  logic [1:0]  sel, sel_nx;
  logic [15:0] scnt;

  logic        host_q, cap_v;
  logic [31:0] cap_idx, cap_dat;
  logic        pend_v;
  logic [31:0] pend_idx, pend_dat;
  logic [31:0] shadow_sw;
  logic        handoff;

  logic        wr_start, wr_done;
  logic [31:0] wr_idx, wr_dat;

  logic [31:0] snap [3];

  assign snap0_o = snap[0];
  assign snap1_o = snap[1];
  assign snap2_o = snap[2];

  bk_bkt_wr_engine u_wr (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (wr_start),
    .idx         (wr_idx),
    .dat         (wr_dat),
    .bkt_ready_o (bkt_ready_o),
    .bkt_index_o (bkt_index_o),
    .bkt_data_o  (bkt_data_o),
    .done        (wr_done)
  );

  // Pending is handed to the engine at HWR entry, so a host edge
  // during HWR queues a fresh request instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_q     <= 1'b0;
      cap_v      <= 1'b0;
      cap_idx    <= '0;
      cap_dat    <= '0;
      pend_v     <= 1'b0;
      pend_idx   <= '0;
      pend_dat   <= '0;
      shadow_sw  <= '0;
      host_ovf_o <= 1'b0;
    end else begin
      host_q <= host_ready_i;
      cap_v  <= host_ready_i & ~host_q;
      if (host_ready_i & ~host_q) begin
        cap_idx <= host_index_i;
        cap_dat <= host_data_i;
      end
      if (handoff)
        pend_v <= 1'b0;
      if (cap_v) begin
        pend_v   <= 1'b1;
        pend_idx <= cap_idx;
        pend_dat <= cap_dat;
        if (pend_v && !handoff)
          host_ovf_o <= 1'b1;
        if (cap_idx == SEL_IDX)
          shadow_sw <= cap_dat;
      end
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    wr_start = 1'b0;
    wr_idx   = SEL_IDX;
    wr_dat   = {30'd0, sel};
    handoff  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pend_v) begin
          state_nx = S_HWR;
          wr_start = 1'b1;
          wr_idx   = pend_idx;
          wr_dat   = pend_dat;
          handoff  = 1'b1;
        end else if (scan_en_i) begin
          state_nx = S_SEL;
          sel_nx   = '0;
          wr_start = 1'b1;
          wr_dat   = '0;
        end
      end
      S_HWR: if (wr_done) state_nx = S_IDLE;
      S_SEL: if (wr_done) state_nx = S_SETTLE;
      S_SETTLE: if (scnt == SETTLE_LAST) state_nx = S_SAMPLE;
      S_SAMPLE: begin
        wr_start = 1'b1;
        if (sel == LAST_SEL || !scan_en_i) begin
          state_nx = S_RST;
          sel_nx   = '0;
          wr_dat   = shadow_sw;
        end else begin
          state_nx = S_SEL;
          sel_nx   = sel + 2'd1;
          wr_dat   = {30'd0, sel + 2'd1};
        end
      end
      S_RST: if (wr_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= '0;
      scnt        <= '0;
      busy_o      <= 1'b0;
      scan_done_o <= 1'b0;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      scnt        <= (state == S_SETTLE) ? scnt + 16'd1 : '0;
      busy_o      <= (state_nx != S_IDLE);
      scan_done_o <= (state == S_RST) && wr_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snap <= '{default: '0};
    else if (state == S_SAMPLE)
      snap[sel] <= bk_status_i;
  end

`ifdef BK_STATUS_SCAN_CHG_EN
  logic [2:0] snap_valid;
  logic [2:0] chg_set;

  always_comb begin
    chg_set = '0;
    if (state == S_SAMPLE && snap_valid[sel] && snap[sel] != bk_status_i)
      chg_set[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid <= '0;
      chg_o      <= '0;
    end else begin
      if (state == S_SAMPLE)
        snap_valid[sel] <= 1'b1;
      chg_o <= (chg_o & ~chg_clr_i) | chg_set;
    end
  end
`else
  logic unused_chg_clr;
  assign unused_chg_clr = ^chg_clr_i;
  assign chg_o = '0;
`endif

endmodule

// File: tb/tb_bk_status_scan.sv
// Self-checking bench for bk_status_scan: job-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_bk_status_scan;

  localparam int NS = 3;
  localparam int ST = 2;
  localparam logic [31:0] SELIDX = 32'd501;
`ifdef BK_STATUS_SCAN_CHG_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        host_ready = 1'b0;
  logic [31:0] host_index = '0;
  logic [31:0] host_data = '0;
  logic [31:0] bk_status = '0;
  logic [2:0]  chg_clr = '0;
  logic        bkt_ready_o;
  logic [31:0] bkt_index_o, bkt_data_o;
  logic [31:0] snap0_o, snap1_o, snap2_o;
  logic [2:0]  chg_o;
  logic        scan_done_o, busy_o, host_ovf_o;

  bk_status_scan dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_en_i    (scan_en),
    .host_ready_i (host_ready),
    .host_index_i (host_index),
    .host_data_i  (host_data),
    .bkt_ready_o  (bkt_ready_o),
    .bkt_index_o  (bkt_index_o),
    .bkt_data_o   (bkt_data_o),
    .bk_status_i  (bk_status),
    .snap0_o      (snap0_o),
    .snap1_o      (snap1_o),
    .snap2_o      (snap2_o),
    .chg_o        (chg_o),
    .chg_clr_i    (chg_clr),
    .scan_done_o  (scan_done_o),
    .busy_o       (busy_o),
    .host_ovf_o   (host_ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: a controller runs one job at a time; each job is
  // expanded into a script of per-cycle bus strobe values.
  typedef enum {J_IDLE, J_HOST, J_SCAN, J_RST} job_t;
  job_t        job;
  bit          scr[$];
  int          m_sel;
  logic [31:0] m_snap[3];
  bit          m_sv[3];
  logic [2:0]  m_chg;
  bit          m_ovf, m_pv, m_hv, m_hprev;
  logic [31:0] m_shadow, m_pidx, m_pdat, m_hidx, m_hdat;
  bit          m_rdy, m_busy, m_done;
  logic [31:0] m_bidx, m_bdat;

  task automatic model_reset();
    job = J_IDLE;
    scr.delete();
    m_sel = 0;
    for (int i = 0; i < 3; i++) begin
      m_snap[i] = '0;
      m_sv[i] = 1'b0;
    end
    m_chg = '0; m_ovf = 0; m_pv = 0; m_hv = 0; m_hprev = 0;
    m_shadow = '0; m_pidx = '0; m_pdat = '0; m_hidx = '0; m_hdat = '0;
    m_rdy = 0; m_busy = 0; m_done = 0; m_bidx = '0; m_bdat = '0;
  endtask

  task automatic push_wr(input logic [31:0] i, input logic [31:0] d);
    m_bidx = i;
    m_bdat = d;
    scr.push_back(1); scr.push_back(1);
    scr.push_back(0); scr.push_back(0);
  endtask

  task automatic push_src();
    push_wr(SELIDX, 32'(m_sel));
    repeat (ST + 1) scr.push_back(0);
  endtask

  task automatic model_step();
    bit hand;
    logic [2:0] setv;
    hand = 0;
    setv = '0;
    m_done = 0;
    if (scr.size() == 0) begin
      case (job)
        J_IDLE:
          if (m_pv) begin
            push_wr(m_pidx, m_pdat); hand = 1; job = J_HOST;
          end else if (scan_en) begin
            m_sel = 0; push_src(); job = J_SCAN;
          end
        J_HOST: job = J_IDLE;
        J_SCAN: begin
          if (CHG && m_sv[m_sel] && m_snap[m_sel] !== bk_status)
            setv[m_sel] = 1'b1;
          m_snap[m_sel] = bk_status;
          m_sv[m_sel] = 1'b1;
          if (m_sel == NS - 1 || !scan_en) begin
            push_wr(SELIDX, m_shadow); job = J_RST;
          end else begin
            m_sel++; push_src();
          end
        end
        J_RST: begin
          job = J_IDLE; m_done = 1;
        end
        default: job = J_IDLE;
      endcase
    end
    m_busy = (scr.size() != 0);
    m_rdy = m_busy ? scr.pop_front() : 1'b0;
    m_chg = CHG ? ((m_chg & ~chg_clr) | setv) : 3'b000;
    if (hand) m_pv = 0;
    if (m_hv) begin
      if (m_pv) m_ovf = 1;
      m_pv = 1; m_pidx = m_hidx; m_pdat = m_hdat;
      if (m_hidx == SELIDX) m_shadow = m_hdat;
    end
    m_hv = host_ready && !m_hprev;
    if (m_hv) begin
      m_hidx = host_index; m_hdat = host_data;
    end
    m_hprev = host_ready;
  endtask

  task automatic compare();
    chk("bkt_ready", bkt_ready_o, m_rdy);
    chk("bkt_index", bkt_index_o, m_bidx);
    chk("bkt_data", bkt_data_o, m_bdat);
    chk("busy", busy_o, m_busy);
    chk("scan_done", scan_done_o, m_done);
    chk("host_ovf", host_ovf_o, m_ovf);
    chk("chg", chg_o, m_chg);
    chk("snap0", snap0_o, m_snap[0]);
    chk("snap1", snap1_o, m_snap[1]);
    chk("snap2", snap2_o, m_snap[2]);
  endtask

  // Switch model: select register follows bus writes to base+1.
  logic [31:0] src[3];
  logic [31:0] sw_sel = '0, sw_pend = '0;
  int          sw_cd = 0;
  bit          prev_rdy = 0, rose = 0;
  logic [31:0] log_idx[$], log_dat[$];

  task automatic tick();
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare();
    rose = bkt_ready_o && !prev_rdy;
    if (rose) begin
      log_idx.push_back(bkt_index_o);
      log_dat.push_back(bkt_data_o);
      if (bkt_index_o == SELIDX) begin
        sw_cd = 3; sw_pend = bkt_data_o;
      end
    end else if (sw_cd > 0) begin
      sw_cd--;
      if (sw_cd == 0) sw_sel = sw_pend;
    end
    prev_rdy = bkt_ready_o;
    if (sw_sel < 3) bk_status = src[sw_sel];
    else bk_status = 32'hdead_0000 ^ sw_sel;
  endtask

  task automatic host_pulse(input logic [31:0] i, input logic [31:0] d);
    host_ready = 1; host_index = i; host_data = d;
    tick();
    host_ready = 0;
    tick();
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    while (!scan_done_o && n < lim) begin
      tick(); n++;
    end
    chk(nm, scan_done_o, 1);
  endtask

  initial begin
    logic [6:0] er, eb;
    int n, bc;
    src[0] = 32'hA0; src[1] = 32'hB1; src[2] = 32'hC2;
    model_reset();
    repeat (2) tick();
    chk("rst_ready", bkt_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_snap0", snap0_o, 0);
    rst_n = 1;
    tick();

    // Idle host write: strobe two cycles, starting two edges later
    er = 7'b0001100;
    eb = 7'b0111100;
    host_ready = 1; host_index = 500; host_data = 5;
    for (int i = 0; i < 7; i++) begin
      tick();
      host_ready = 0;
      chk("hw_ready_pat", bkt_ready_o, er[i]);
      chk("hw_busy_pat", busy_o, eb[i]);
      if (i >= 2 && i <= 5) begin
        chk("hw_index", bkt_index_o, 500);
        chk("hw_data", bkt_data_o, 5);
      end
    end

    // Full sweep
    log_idx.delete(); log_dat.delete();
    scan_en = 1;
    n = 0; bc = 0;
    while (!scan_done_o && n < 80) begin
      tick(); n++;
      if (busy_o) bc++;
    end
    scan_en = 0;
    chk("sweep_done", scan_done_o, 1);
    chk("sweep_len", bc, 25);
    chk("snap0_lit", snap0_o, 32'hA0);
    chk("snap1_lit", snap1_o, 32'hB1);
    chk("snap2_lit", snap2_o, 32'hC2);
    chk("sweep_wr_cnt", log_idx.size(), 4);
    if (log_idx.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("sweep_wr_idx", log_idx[i], SELIDX);
        chk("sweep_wr_dat", log_dat[i], (i == 3) ? 0 : i);
      end
    repeat (3) tick();

    // Host writes mid-sweep, then overwrite of pending
    scan_en = 1;
    repeat (5) tick();
    host_pulse(SELIDX, 2);
    wait_done("sweep_a_done", 60);
    repeat (8) tick();
    host_pulse(500, 7);
    repeat (3) tick();
    host_pulse(500, 9);
    wait_done("sweep_b_done", 80);
    chk("restore_shadow", log_dat[$], 2);
    scan_en = 0;
    repeat (12) tick();
    chk("ovf_lit", host_ovf_o, 1);
    chk("ovf_last_idx", log_idx[$], 500);
    chk("ovf_last_dat", log_dat[$], 9);

    // Change detection on source 1
    src[1] = 32'hB7;
    scan_en = 1;
    wait_done("chg_sweep_done", 60);
    scan_en = 0;
    chk("chg_lit", chg_o, CHG ? 3'b010 : 3'b000);
    chg_clr = 3'b111;
    tick();
    chg_clr = 3'b000;
    chk("chg_clr_lit", chg_o, 0);
    repeat (3) tick();

    // scan_en dropped during SETTLE of source 1
    src[1] = 32'hB1; src[2] = 32'hEE;
    scan_en = 1;
    n = 0;
    do begin
      tick(); n++;
    end while (!(rose && bkt_index_o == SELIDX && bkt_data_o == 1) && n < 40);
    chk("abort_sel1_seen", bkt_data_o, 1);
    repeat (4) tick();
    scan_en = 0;
    wait_done("abort_done", 40);
    chk("abort_snap1", snap1_o, 32'hB1);
    chk("abort_snap2", snap2_o, 32'hC2);
    tick();
    chk("abort_idle", busy_o, 0);

    // Asynchronous reset during a write
    host_ready = 1; host_index = 500; host_data = 32'h33;
    tick();
    host_ready = 0;
    n = 0;
    while (!bkt_ready_o && n < 10) begin
      tick(); n++;
    end
    chk("rstw_seen", bkt_ready_o, 1);
    #1 rst_n = 0;
    #1;
    chk("rstw_ready", bkt_ready_o, 0);
    chk("rstw_index", bkt_index_o, 0);
    chk("rstw_busy", busy_o, 0);
    chk("rstw_ovf", host_ovf_o, 0);
    chk("rstw_snap1", snap1_o, 0);
    model_reset();
    prev_rdy = 0;
    repeat (2) tick();
    rst_n = 1;
    host_pulse(500, 32'h44);
    repeat (8) tick();
    chk("post_rst_idx", log_idx[$], 500);
    chk("post_rst_dat", log_dat[$], 32'h44);

    // Random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      if (host_ready) begin
        if ($urandom_range(0, 1) == 0) host_ready = 0;
      end else if ($urandom_range(0, 11) == 0) begin
        host_ready = 1;
        if ($urandom_range(0, 1) == 0) begin
          host_index = SELIDX; host_data = $urandom_range(0, 2);
        end else begin
          host_index = 500; host_data = $urandom;
        end
      end
      if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
      chg_clr = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 29) == 0)
        src[$urandom_range(0, 2)] = $urandom_range(0, 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
